// File: rtl/systolic_seq_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StFlush,
        StDrain,
        StDone
    } state_e;

    // Cycles needed for the last operand pair to reach PE(N-1,N-1) and land.
    function automatic int unsigned flush_cyc(input int unsigned n);
        return 2 * n;
    endfunction

    // Lane i of a packed byte-lane vector occupies bits [8i+7:8i].
    function automatic int unsigned lane_lsb(input int unsigned i);
        return 8 * i;
    endfunction

endpackage

// File: rtl/systolic_seq_if.sv
// Job control, operand buffer, array edge and result drain signals of the sequencer.
interface systolic_seq_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned K_W    = 8
);
    localparam int unsigned IDX_W = $clog2(N * N);

    logic                start;
    logic [K_W-1:0]      k_len;
    logic [ADDR_W-1:0]   a_base;
    logic [ADDR_W-1:0]   w_base;
    logic                busy;
    logic                done;
    logic                a_rd_en;
    logic [ADDR_W-1:0]   a_rd_addr;
    logic [N*8-1:0]      a_rd_data;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [N*8-1:0]      w_rd_data;
    logic                arr_clr_n;
    logic [N*8-1:0]      a_feed;
    logic [N*8-1:0]      w_feed;
    logic [N-1:0]        fire_edge;
    logic [N*N*32-1:0]   acc_in;
    logic                res_valid;
    logic                res_ready;
    logic [31:0]         res_data;
    logic [IDX_W-1:0]    res_idx;

    modport slave (
        input  start, k_len, a_base, w_base, a_rd_data, w_rd_data, acc_in, res_ready,
        output busy, done, a_rd_en, a_rd_addr, w_rd_en, w_rd_addr, arr_clr_n,
               a_feed, w_feed, fire_edge, res_valid, res_data, res_idx
    );

    modport master (
        output start, k_len, a_base, w_base, a_rd_data, w_rd_data, acc_in, res_ready,
        input  busy, done, a_rd_en, a_rd_addr, w_rd_en, w_rd_addr, arr_clr_n,
               a_feed, w_feed, fire_edge, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/systolic_seq_skew_line.sv
// Triangular delay line: lane i is delayed by i register stages, lane 0 passes through.
module skew_line #(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [LANES*W-1:0] din,
    output logic [LANES*W-1:0] dout
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign dout[W-1:0] = din[W-1:0];
        end else begin : g_dly
            logic [W-1:0] sr_q [i];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < i; s++) sr_q[s] <= '0;
                end else begin
                    sr_q[0] <= din[i*W +: W];
                    for (int s = 1; s < i; s++) sr_q[s] <= sr_q[s-1];
                end
            end

            assign dout[i*W +: W] = sr_q[i-1];
        end
    end

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for an N x N output-stationary systolic array: clear, feed, flush, drain.
module systolic_seq #(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned K_W    = 8
) (
    input  logic           clk,
    input  logic           rstn,
    systolic_seq_if.slave  bus
);
    import systolic_seq_pkg::*;

    localparam int unsigned FLUSH_CYC = flush_cyc(N);
    localparam int unsigned FLUSH_W   = $clog2(FLUSH_CYC);
    localparam int unsigned IDX_W     = $clog2(N * N);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N * N - 1);
    localparam logic [FLUSH_W-1:0] LAST_FLSH = FLUSH_W'(FLUSH_CYC - 1);

    state_e             state_q;
    logic [K_W-1:0]     k_q;
    logic [K_W-1:0]     k_len_q;
    logic [ADDR_W-1:0]  a_base_q;
    logic [ADDR_W-1:0]  w_base_q;
    logic [FLUSH_W-1:0] flush_q;
    logic [IDX_W-1:0]   idx_q;
    logic               rd_en_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            k_q      <= '0;
            k_len_q  <= '0;
            a_base_q <= '0;
            w_base_q <= '0;
            flush_q  <= '0;
            idx_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && (bus.k_len != '0)) begin
                        k_len_q  <= bus.k_len;
                        a_base_q <= bus.a_base;
                        w_base_q <= bus.w_base;
                        k_q      <= '0;
                        state_q  <= StClear;
                    end
                end
                StClear: state_q <= StFeed;
                StFeed: begin
                    if (k_q == k_len_q - K_W'(1)) begin
                        k_q     <= '0;
                        flush_q <= '0;
                        state_q <= StFlush;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                StFlush: begin
                    if (flush_q == LAST_FLSH) begin
                        flush_q <= '0;
                        idx_q   <= '0;
                        state_q <= StDrain;
                    end else begin
                        flush_q <= flush_q + FLUSH_W'(1);
                    end
                end
                StDrain: begin
                    if (bus.res_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Buffer data is valid the cycle after a read; outside that window lanes carry zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rd_en_q <= 1'b0;
        else       rd_en_q <= (state_q == StFeed);
    end

    logic [N*8-1:0] a_src, w_src, a_skew, w_skew;
    logic [N-1:0]   fire_src, fire_skew;

    assign a_src    = rd_en_q ? bus.a_rd_data : '0;
    assign w_src    = rd_en_q ? bus.w_rd_data : '0;
    assign fire_src = {N{rd_en_q}};

    skew_line #(.LANES(N), .W(8)) u_a_skew (
        .clk  (clk),
        .rstn (rstn),
        .din  (a_src),
        .dout (a_skew)
    );

    skew_line #(.LANES(N), .W(8)) u_w_skew (
        .clk  (clk),
        .rstn (rstn),
        .din  (w_src),
        .dout (w_skew)
    );

    skew_line #(.LANES(N), .W(1)) u_fire_skew (
        .clk  (clk),
        .rstn (rstn),
        .din  (fire_src),
        .dout (fire_skew)
    );

    assign bus.a_feed    = a_skew;
    assign bus.w_feed    = w_skew;
    assign bus.fire_edge = fire_skew;

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.arr_clr_n = (state_q != StClear);
    assign bus.a_rd_en   = (state_q == StFeed);
    assign bus.w_rd_en   = (state_q == StFeed);
    assign bus.a_rd_addr = (state_q == StFeed) ? a_base_q + ADDR_W'(k_q) : '0;
    assign bus.w_rd_addr = (state_q == StFeed) ? w_base_q + ADDR_W'(k_q) : '0;
    assign bus.res_valid = (state_q == StDrain);
    assign bus.res_idx   = idx_q;
    assign bus.res_data  = bus.acc_in[{idx_q, 5'd0} +: 32];

endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
- Sequencer for an N x N output-stationary systolic array of 8-bit MAC PEs.
- PE(r,c) registers activation right, weight down and fire along with the data, and accumulates into a 32-bit register.
- Per job: clears the array, streams k_len activation/weight words from two read-only buffers, and skews the edge lanes so operands meet diagonally.
- Waits for the wavefront to flush, then drains the N*N accumulators row-major over a valid/ready port.

Parameters:
N, 4, array dimension (rows = columns = lanes)
ADDR_W, 10, buffer address width
K_W, 8, width of k_len

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  job request, sampled in IDLE only
k_len  in  K_W  reduction length; latched at accepted start
a_base  in  ADDR_W  activation buffer base; latched at start
w_base  in  ADDR_W  weight buffer base; latched at start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after final drain handshake
a_rd_en  out  1  activation buffer read strobe
a_rd_addr  out  ADDR_W  activation address
a_rd_data  in  N*8  word k: lane r = A[r][k]; valid 1 cycle after a_rd_en
w_rd_en  out  1  weight buffer read strobe
w_rd_addr  out  ADDR_W  weight address
w_rd_data  in  N*8  word k: lane c = W[k][c]; valid 1 cycle after w_rd_en
arr_clr_n  out  1  synchronous active-low clear to all PEs
a_feed  out  N*8  left-edge activation lanes
w_feed  out  N*8  top-edge weight lanes
fire_edge  out  N  left-edge fire, lane r aligned with a_feed lane r
acc_in  in  N*N*32  PE accumulators, index r*N+c
res_valid  out  1  drain data valid
res_ready  in  1  downstream accept
res_data  out  32  acc_in[res_idx]
res_idx  out  $clog2(N*N)  current drain index

Behaviour:
- Reset (async, rstn=0): state=IDLE; all counters, skew registers and outputs 0, except arr_clr_n=1.
- Reset at any point aborts the job; no done is produced.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE. Outputs decode from the state register plus counters.
- IDLE:
  - start=1 and k_len!=0 -> latch k_len, a_base, w_base; go to CLEAR.
  - start with k_len=0 is ignored (stay IDLE, no done).
- start is ignored in every state except IDLE.
- CLEAR: 1 cycle; arr_clr_n=0 -> FEED.
- FEED: k_len cycles, k = 0..k_len-1.
  - a_rd_en=w_rd_en=1.
  - a_rd_addr = a_base+k, w_rd_addr = w_base+k, both modulo 2^ADDR_W (wrap allowed).
  - After k = k_len-1 -> FLUSH.
- Skew: lane i of a_feed/w_feed = rd_data lane i delayed by i registers; lane 0 is combinational pass-through.
- Lanes hold 0 when no data is in flight.
- fire_edge[i] = a_rd_en delayed by 1+i registers.
- FLUSH: exactly 2N cycles -> DRAIN. Last PE(N-1,N-1) update lands before DRAIN begins.
- DRAIN:
  - res_valid=1; res_idx starts at 0.
  - Advance on res_valid & res_ready; res_data is stable while res_ready=0.
  - Handshake at res_idx = N*N-1 -> DONE.
- DONE: done=1 for 1 cycle -> IDLE.
- Timing, start accepted at edge ending cycle 0:
  - CLEAR in cycle 1.
  - rd_en in cycles 2..k_len+1.
  - fire_edge[i] in cycles 3+i..k_len+2+i.
  - FLUSH in cycles k_len+2..k_len+2N+1.
  - First res_valid in cycle k_len+2N+2.
- Accumulator width and overflow are the PE's concern; this block only selects.

Decomposition:
- Shared package: state enum, FLUSH_CYC = 2*N, lane slicing helper (lane i = bits [8i+7:8i]).
- One sub-module, skew_line (params LANES, W): triangular delay line with async reset.
  - Instantiated twice for a_feed/w_feed.
  - fire_edge uses a 1-bit instance plus one extra register stage.

Test Plan:
- N=2, A=[[1,2],[3,4]], W=[[5,6],[7,8]], k_len=2, res_ready=1 -> res_data 19,22,43,50 at res_idx 0..3, then one done pulse.
- Same job, timing check -> arr_clr_n low cycle 1; rd_en cycles 2-3; fire_edge[0] cycles 3-4; fire_edge[1] cycles 4-5; res_valid first in cycle 8.
- a_base=1023, k_len=3 -> a_rd_addr 1023,0,1; start pulses during busy -> ignored, one done only.
- start with k_len=0 -> busy stays 0, no rd_en, no done.
- Drain backpressure: res_ready toggled 0/1 every cycle -> each index presented until accepted, values unchanged, no skipped or repeated index.
- rstn low mid-FEED -> all outputs reset within the same cycle, busy=0, no done; next job yields correct results.
